// File: rtl/mag_duty_ctrl.sv
// Magnetron cooking controller: start/stop/pause state machine with a door
// interlock and a tick-driven duty window that sets on-ticks per window by power level.
module mag_duty_ctrl #(
  parameter int LEVEL_W = 3,
  parameter int WINDOW  = 8,
  parameter int PH_W    = $clog2(WINDOW)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               S,
  input  logic               R,
  input  logic               door_open,
  input  logic               tick,
  input  logic [LEVEL_W-1:0] level,
  output logic               mag_on,
  output logic               cooking,
  output logic               paused
);

  localparam int CW = ((LEVEL_W > PH_W) ? LEVEL_W : PH_W) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic            magReg_q, magReg_d;
  logic            cooking_q, paused_q;

  logic [CW-1:0]   levelExt;
  logic [CW-1:0]   windowExt;
  logic [CW-1:0]   lvlEff;
  logic [CW-1:0]   phaseExt;

  // R always wins; a tick coinciding with leaving COOK is dropped because
  // only the "stay in COOK" branch advances the phase.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (S && !R && !door_open) begin
          state_d = COOK;
        end
      end
      COOK: begin
        if (R) begin
          state_d = IDLE;
          phase_d = '0;
        end else if (door_open) begin
          state_d = PAUSE;
        end else if (tick) begin
          phase_d = (phase_q == PH_W'(WINDOW - 1)) ? '0 : phase_q + 1'b1;
        end
      end
      PAUSE: begin
        if (R) begin
          state_d = IDLE;
          phase_d = '0;
        end else if (!door_open && S) begin
          state_d = COOK;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
  end

  // Duty decision uses next-state values so mag_on rises together with cooking.
  always_comb begin
    levelExt  = CW'(level);
    windowExt = CW'(WINDOW);
    lvlEff    = (levelExt > windowExt) ? windowExt : levelExt;
    phaseExt  = CW'(phase_d);
    magReg_d  = (state_d == COOK) && (phaseExt < lvlEff);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      magReg_q  <= 1'b0;
      cooking_q <= 1'b0;
      paused_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      magReg_q  <= magReg_d;
      cooking_q <= (state_d == COOK);
      paused_q  <= (state_d == PAUSE);
    end
  end

  // The door gate is deliberately combinational so the magnetron cuts out
  // in the very cycle the door opens.
  assign mag_on  = magReg_q & ~door_open;
  assign cooking = cooking_q;
  assign paused  = paused_q;

endmodule

// File: tb/tb_mag_duty_ctrl.sv
// Self-checking bench for mag_duty_ctrl: two instances (WINDOW=8 and WINDOW=4)
// share stimulus and are compared every half cycle against a behavioural model.
module tb_mag_duty_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       S = 1'b0;
  logic       R = 1'b0;
  logic       door_open = 1'b0;
  logic       tick = 1'b0;
  logic [2:0] level = 3'd3;

  logic magOn8, cooking8, paused8;
  logic magOn4, cooking4, paused4;

  int vectors = 0;
  int miscompares = 0;

  mag_duty_ctrl #(.LEVEL_W(3), .WINDOW(8)) u8 (
    .clk(clk), .rst_n(rst_n), .S(S), .R(R), .door_open(door_open),
    .tick(tick), .level(level), .mag_on(magOn8), .cooking(cooking8), .paused(paused8)
  );

  mag_duty_ctrl #(.LEVEL_W(3), .WINDOW(4)) u4 (
    .clk(clk), .rst_n(rst_n), .S(S), .R(R), .door_open(door_open),
    .tick(tick), .level(level), .mag_on(magOn4), .cooking(cooking4), .paused(paused4)
  );

  always #5 clk = ~clk;

  // Behavioural model: index 0 is the WINDOW=8 instance, index 1 the WINDOW=4 one.
  bit mCook[2];
  bit mPause[2];
  int mPhase[2];
  bit mMagReg[2];
  bit started = 1'b0;

  function automatic int winOf(input int i);
    return (i == 0) ? 8 : 4;
  endfunction

  task automatic modelStep();
    for (int i = 0; i < 2; i++) begin
      int lvlEff;
      if (!rst_n) begin
        mCook[i] = 0; mPause[i] = 0; mPhase[i] = 0;
      end else if (mCook[i]) begin
        if (R) begin
          mCook[i] = 0; mPhase[i] = 0;
        end else if (door_open) begin
          mCook[i] = 0; mPause[i] = 1;
        end else if (tick) begin
          mPhase[i] = (mPhase[i] + 1) % winOf(i);
        end
      end else if (mPause[i]) begin
        if (R) begin
          mPause[i] = 0; mPhase[i] = 0;
        end else if (!door_open && S) begin
          mPause[i] = 0; mCook[i] = 1;
        end
      end else begin
        mPhase[i] = 0;
        if (S && !R && !door_open) mCook[i] = 1;
      end
      lvlEff = (int'(level) < winOf(i)) ? int'(level) : winOf(i);
      mMagReg[i] = mCook[i] && (mPhase[i] < lvlEff);
      if (!rst_n) mMagReg[i] = 0;
    end
    if (!rst_n) started = 1'b1;
  endtask

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, actual, expected);
    end
  endtask

  task automatic checkInt(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Compare process: registered outputs just after each rising edge, and the
  // combinational door gate just after inputs change on the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      modelStep();
      #2;
      if (started) begin
        checkOutput("u8_mag_on",  magOn8,   mMagReg[0] & ~door_open);
        checkOutput("u8_cooking", cooking8, mCook[0]);
        checkOutput("u8_paused",  paused8,  mPause[0]);
        checkOutput("u4_mag_on",  magOn4,   mMagReg[1] & ~door_open);
        checkOutput("u4_cooking", cooking4, mCook[1]);
        checkOutput("u4_paused",  paused4,  mPause[1]);
      end
      @(negedge clk);
      #2;
      if (started) begin
        checkOutput("u8_mag_on_gate", magOn8, mMagReg[0] & ~door_open);
        checkOutput("u4_mag_on_gate", magOn4, mMagReg[1] & ~door_open);
      end
    end
  end

  // Drives one cycle of inputs at the falling edge and returns just after the
  // following rising edge, once the compare process has updated the model.
  task automatic applyStimulus(input logic rn, input logic s, input logic r,
                               input logic d, input logic t, input logic [2:0] lv);
    @(negedge clk);
    rst_n = rn; S = s; R = r; door_open = d; tick = t; level = lv;
    @(posedge clk);
    #3;
  endtask

  initial begin
    // Reset and idle start, then the 3-of-8 duty pattern with a tick every 4 clocks.
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 3'd3);
      checkOutput("rst_mag_on", magOn8, 1'b0);
      checkOutput("rst_cooking", cooking8, 1'b0);
      checkOutput("rst_paused", paused8, 1'b0);
    end
    applyStimulus(1, 1, 0, 0, 0, 3'd3);
    checkOutput("start_cooking", cooking8, 1'b1);
    checkOutput("start_mag_on", magOn8, 1'b1);
    for (int k = 0; k < 16; k++) begin
      for (int c = 0; c < 3; c++) applyStimulus(1, 0, 0, 0, 0, 3'd3);
      applyStimulus(1, 0, 0, 0, 1, 3'd3);
      checkOutput("duty_pattern", magOn8, ((k + 1) % 8) < 3);
    end

    // S and R together in IDLE.
    applyStimulus(1, 0, 1, 0, 0, 3'd3);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 1, 0, 0, 3'd3);
      checkOutput("sr_cooking", cooking8, 1'b0);
      checkOutput("sr_mag_on", magOn8, 1'b0);
    end

    // Door opens at phase 1: gate drops immediately, pause holds phase.
    applyStimulus(1, 1, 0, 0, 0, 3'd3);
    applyStimulus(1, 0, 0, 0, 1, 3'd3);
    checkInt("model_phase_before_door", mPhase[0], 1);
    @(negedge clk);
    door_open = 1; tick = 0;
    #2;
    checkOutput("door_gate_same_cycle", magOn8, 1'b0);
    @(posedge clk);
    #3;
    checkOutput("door_paused", paused8, 1'b1);
    for (int k = 0; k < 5; k++) applyStimulus(1, 0, 0, 1, 1, 3'd3);
    checkInt("model_phase_in_pause", mPhase[0], 1);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 0, 0, 0, 0, 3'd3);
      checkOutput("no_auto_resume", paused8, 1'b1);
    end
    applyStimulus(1, 1, 0, 0, 0, 3'd3);
    checkOutput("resume_cooking", cooking8, 1'b1);
    checkOutput("resume_mag_ph1", magOn8, 1'b1);
    applyStimulus(1, 0, 0, 0, 1, 3'd3);
    checkOutput("resume_mag_ph2", magOn8, 1'b1);
    applyStimulus(1, 0, 0, 0, 1, 3'd3);
    checkOutput("resume_mag_ph3", magOn8, 1'b0);

    // R wins over door and tick in COOK; fresh start at phase 0.
    applyStimulus(1, 0, 1, 1, 1, 3'd3);
    checkOutput("stop_cooking", cooking8, 1'b0);
    checkOutput("stop_paused", paused8, 1'b0);
    checkInt("model_phase_after_stop", mPhase[0], 0);
    applyStimulus(1, 1, 0, 0, 0, 3'd3);
    checkOutput("restart_mag_ph0", magOn8, 1'b1);

    // level=0 for a full window.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 0, 0, 0, 1, 3'd0);
      checkOutput("lvl0_mag_on", magOn8, 1'b0);
      checkOutput("lvl0_cooking", cooking8, 1'b1);
    end

    // level=7 saturates the WINDOW=4 instance, then drops to 1 at phase 2.
    applyStimulus(1, 0, 1, 0, 0, 3'd7);
    applyStimulus(1, 1, 0, 0, 0, 3'd7);
    for (int k = 0; k < 4; k++) begin
      checkOutput("w4_full_on", magOn4, 1'b1);
      applyStimulus(1, 0, 0, 0, 1, 3'd7);
    end
    applyStimulus(1, 0, 0, 0, 1, 3'd7);
    applyStimulus(1, 0, 0, 0, 1, 3'd7);
    checkOutput("lvl7_ph2_on", magOn8, 1'b1);
    applyStimulus(1, 0, 0, 0, 0, 3'd1);
    checkOutput("lvl_drop_u8", magOn8, 1'b0);
    checkOutput("lvl_drop_u4", magOn4, 1'b0);

    // Reset mid-COOK with tick and S asserted.
    applyStimulus(0, 1, 0, 0, 1, 3'd3);
    checkOutput("midrst_cooking", cooking8, 1'b0);
    checkOutput("midrst_mag_on", magOn8, 1'b0);
    checkInt("model_phase_midrst", mPhase[0], 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 0, 0, 1, 3'd3);
      checkOutput("post_rst_idle", cooking8, 1'b0);
    end
    applyStimulus(1, 1, 0, 0, 0, 3'd3);
    checkOutput("post_rst_start", cooking8, 1'b1);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      applyStimulus(($urandom_range(0, 39) != 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 1) == 0),
                    3'($urandom_range(0, 7)));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
